// File: rtl/sync_ram.sv
// Single-port synchronous RAM with request/ready handshake and optional zero-fill sweep.
// Read latency 1 cycle (out_valid pulse); ready is low during a sweep or while clear is asserted.
module sync_ram #(
    parameter int DATA_W     = 4,
    parameter int ADDR_W     = 2,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memory_en,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    input  logic              clear,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              ready,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam state_t RST_STATE = (INIT_CLEAR != 0) ? CLEAR : IDLE;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic              sweep_en;

    assign ready    = (state == IDLE) && !clear;
    assign busy     = (state == CLEAR);
    // Nothing may touch the array or the read path while reset is held.
    assign accept   = memory_en && ready && !rst;
    assign wr_en    = accept && read_write;
    assign rd_en    = accept && !read_write;
    assign sweep_en = busy && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RST_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                if (clear) begin
                    clr_cnt_nxt = '0;
                end else if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt   = IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt   = RST_STATE;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // Array has no reset: contents change only via accepted writes or the sweep.
    always_ff @(posedge clk) begin
        if (sweep_en) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            mem[address] <= in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_en;
            if (rd_en) begin
                out <= mem[address];
            end
        end
    end

endmodule

// File: tb/tb_sync_ram.sv
// Scoreboard bench for sync_ram: default instance (sweep on reset) and an 8x16 instance without sweep.
module tb_sync_ram;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instance A: defaults ----------------
    logic       a_rst = 1'b1;
    logic       a_en = 1'b0, a_rw = 1'b0, a_clear = 1'b0;
    logic [1:0] a_addr = '0;
    logic [3:0] a_in = '0;
    logic [3:0] a_out;
    logic       a_vld, a_ready, a_busy;

    sync_ram dut_a (
        .clk(clk), .rst(a_rst), .memory_en(a_en), .read_write(a_rw),
        .address(a_addr), .in(a_in), .clear(a_clear),
        .out(a_out), .out_valid(a_vld), .ready(a_ready), .busy(a_busy)
    );

    // ---------------- instance B: 8-bit x 16, no sweep ----------------
    logic       b_rst = 1'b1;
    logic       b_en = 1'b0, b_rw = 1'b0, b_clear = 1'b0;
    logic [3:0] b_addr = '0;
    logic [7:0] b_in = '0;
    logic [7:0] b_out;
    logic       b_vld, b_ready, b_busy;

    sync_ram #(.DATA_W(8), .ADDR_W(4), .INIT_CLEAR(0)) dut_b (
        .clk(clk), .rst(b_rst), .memory_en(b_en), .read_write(b_rw),
        .address(b_addr), .in(b_in), .clear(b_clear),
        .out(b_out), .out_valid(b_vld), .ready(b_ready), .busy(b_busy)
    );

    // ---------------- reference models ----------------
    // A sweep is unobservable from outside (no access until it finishes),
    // so the model zeroes the whole array when one starts and counts down its length.
    logic [3:0] ma_mem [4];
    int         ma_sweep = 4;
    bit         ma_exp_vld = 1'b0;
    logic [3:0] qa[$];

    always @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            ma_sweep   = 4;
            ma_exp_vld = 1'b0;
            qa.delete();
            foreach (ma_mem[i]) ma_mem[i] = 4'h0;
        end else begin
            ma_exp_vld = 1'b0;
            if (a_clear) begin
                ma_sweep = 4;
                foreach (ma_mem[i]) ma_mem[i] = 4'h0;
            end else if (ma_sweep > 0) begin
                ma_sweep--;
            end else if (a_en) begin
                if (a_rw) begin
                    ma_mem[a_addr] = a_in;
                end else begin
                    qa.push_back(ma_mem[a_addr]);
                    ma_exp_vld = 1'b1;
                end
            end
        end
    end

    logic [7:0] mb_mem [16];
    bit         mb_known [16];
    int         mb_sweep = 0;
    bit         mb_exp_vld = 1'b0;
    logic [8:0] qb[$];

    always @(posedge clk or posedge b_rst) begin
        if (b_rst) begin
            mb_sweep   = 0;
            mb_exp_vld = 1'b0;
            qb.delete();
        end else begin
            mb_exp_vld = 1'b0;
            if (b_clear) begin
                mb_sweep = 16;
                foreach (mb_mem[i]) begin
                    mb_mem[i]   = 8'h00;
                    mb_known[i] = 1'b1;
                end
            end else if (mb_sweep > 0) begin
                mb_sweep--;
            end else if (b_en) begin
                if (b_rw) begin
                    mb_mem[b_addr]   = b_in;
                    mb_known[b_addr] = 1'b1;
                end else begin
                    qb.push_back({mb_known[b_addr], mb_mem[b_addr]});
                    mb_exp_vld = 1'b1;
                end
            end
        end
    end

    // ---------------- monitors ----------------
    logic [3:0] a_exp_dat;
    logic [8:0] b_exp_ent;

    initial begin
        foreach (mb_known[i]) mb_known[i] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (a_rst) begin
                check("a_rst_out", a_out, 0);
                check("a_rst_out_valid", a_vld, 0);
                check("a_rst_busy", a_busy, 1);
            end else begin
                check("a_busy", a_busy, ma_sweep > 0);
                check("a_ready", a_ready, (ma_sweep == 0) && !a_clear);
                check("a_out_valid", a_vld, ma_exp_vld);
                if (a_vld) begin
                    if (qa.size() == 0) begin
                        check("a_unexpected_read", a_vld, 0);
                    end else begin
                        a_exp_dat = qa.pop_front();
                        check("a_read_data", a_out, a_exp_dat);
                    end
                end
            end
            if (b_rst) begin
                check("b_rst_out", b_out, 0);
                check("b_rst_out_valid", b_vld, 0);
                check("b_rst_busy", b_busy, 0);
            end else begin
                check("b_busy", b_busy, mb_sweep > 0);
                check("b_ready", b_ready, (mb_sweep == 0) && !b_clear);
                check("b_out_valid", b_vld, mb_exp_vld);
                if (b_vld) begin
                    if (qb.size() == 0) begin
                        check("b_unexpected_read", b_vld, 0);
                    end else begin
                        b_exp_ent = qb.pop_front();
                        if (b_exp_ent[8]) check("b_read_data", b_out, b_exp_ent[7:0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic a_drive(input bit en, input bit rw, input int addr, input int d, input bit clr);
        @(negedge clk);
        a_en = en; a_rw = rw; a_addr = addr[1:0]; a_in = d[3:0]; a_clear = clr;
    endtask

    task automatic a_idle(input int n);
        repeat (n) a_drive(0, 0, 0, 0, 0);
    endtask

    task automatic b_drive(input bit en, input bit rw, input int addr, input int d, input bit clr);
        @(negedge clk);
        b_en = en; b_rw = rw; b_addr = addr[3:0]; b_in = d[7:0]; b_clear = clr;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        a_rst = 1'b0;
        b_rst = 1'b0;
        // Sweep after reset, then every word reads back zero.
        a_idle(4);
        for (int i = 0; i < 4; i++) a_drive(1, 0, i, 0, 0);
        // Write then immediate read of the same address.
        a_drive(1, 1, 2, 4'hA, 0);
        a_drive(1, 0, 2, 0, 0);
        // Fill, then back-to-back reads.
        for (int i = 0; i < 4; i++) a_drive(1, 1, i, i + 1, 0);
        for (int i = 0; i < 4; i++) a_drive(1, 0, i, 0, 0);
        // Clear wins over a simultaneous write.
        a_drive(1, 1, 1, 4'hF, 1);
        a_idle(4);
        a_drive(1, 0, 1, 0, 0);
        // Reset during the second sweep cycle, with non-zero data on out.
        a_drive(1, 1, 3, 4'h7, 0);
        a_drive(1, 0, 3, 0, 0);
        a_drive(0, 0, 0, 0, 1);
        a_idle(1);
        @(negedge clk);
        a_rst = 1'b1;
        #1;
        check("a_rst_async_out", a_out, 0);
        check("a_rst_async_out_valid", a_vld, 0);
        @(negedge clk);
        a_rst = 1'b0;
        a_idle(5);
        for (int i = 0; i < 4; i++) a_drive(1, 0, i, 0, 0);
        // Randomized traffic on A.
        repeat (400) begin
            a_drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3),
                    $urandom_range(0, 15), $urandom_range(0, 29) == 0);
        end
        a_idle(6);

        // Instance B: top-address write must not disturb its neighbour.
        b_drive(1, 1, 14, 8'h33, 0);
        b_drive(1, 1, 15, 8'h5A, 0);
        b_drive(1, 0, 15, 0, 0);
        b_drive(1, 0, 14, 0, 0);
        b_drive(0, 0, 0, 0, 0);
        repeat (300) begin
            b_drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 15),
                    $urandom_range(0, 255), $urandom_range(0, 99) == 0);
        end
        b_drive(0, 0, 0, 0, 0);
        repeat (20) @(negedge clk);

        check("a_scoreboard_drained", qa.size(), 0);
        check("b_scoreboard_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
